// File: rtl/scm_rf_pkg.sv
// ---------------------------------------------------------------------------
// scm_rf_pkg
//
// Shared definitions for the latch-based standard-cell register file:
//   - init_state_e      : state of the zero-fill sequencer (INIT -> READY)
//   - calc_raddr_width  : read word address width from the row/word geometry
//   - is_pow2           : geometry check used by the top at elaboration time
// ---------------------------------------------------------------------------
package scm_rf_pkg;

    // The sequencer only ever walks forward: zero-fill, then serve traffic.
    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Row address bits plus the bits that pick a narrow word inside a row.
    function automatic int calc_raddr_width(input int waddr_width,
                                            input int wdata_width,
                                            input int rdata_width);
        return waddr_width + $clog2(wdata_width / rdata_width);
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/scm_latch_row.sv
// ---------------------------------------------------------------------------
// scm_latch_row
//
// One row of RATIO narrow latch words. Each word has its own gated clock,
// opened only when this row is selected and that word's mask bit is set.
// All words share the same row-wide data input.
//
// Ports:
//   clk     in  clock
//   rst     in  reset, holds every word latch closed while asserted
//   row_en  in  this row is the target of the pending write
//   word_en in  per-word write mask (RATIO bits)
//   data    in  row-wide write data, word k at data[k*RDATA_WIDTH +: RDATA_WIDTH]
//   words   out current latch contents, one entry per word
// ---------------------------------------------------------------------------
module scm_latch_row #(
    parameter int RATIO       = 2,
    parameter int RDATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                row_en,
    input  logic [RATIO-1:0]                    word_en,
    input  logic [RATIO*RDATA_WIDTH-1:0]        data,
    output logic [RATIO-1:0][RDATA_WIDTH-1:0]   words
);

    for (genvar k = 0; k < RATIO; k++) begin : g_word
        logic                   gated_clk;
        logic [RDATA_WIDTH-1:0] word_q;

        tc_clk_gating u_clk_gate (
            .clk       (clk),
            .en        (row_en & word_en[k]),
            .test_en   (1'b0),
            .gated_clk (gated_clk)
        );

        // Reset overrides the gated clock so a write that was sampled just
        // before reset can never reach the array.
        always_latch begin
            if (gated_clk && !rst) begin
                word_q <= data[k*RDATA_WIDTH +: RDATA_WIDTH];
            end
        end

        assign words[k] = word_q;
    end

endmodule

// File: rtl/tc_clk_gating.sv
// ---------------------------------------------------------------------------
// tc_clk_gating
//
// Glitch-free clock gate: the enable is captured by a latch that is
// transparent while the clock is low, so the gated clock can only start or
// stop on a whole high phase.
//
// Ports:
//   clk       in  source clock
//   en        in  functional enable
//   test_en   in  forces the gate open (scan)
//   gated_clk out gated clock
// ---------------------------------------------------------------------------
module tc_clk_gating (
    input  logic clk,
    input  logic en,
    input  logic test_en,
    output logic gated_clk
);

    logic en_latched;

    always_latch begin
        if (!clk) begin
            en_latched <= en | test_en;
        end
    end

    assign gated_clk = clk & en_latched;

endmodule

// File: rtl/register_file_1w_multi_row_multi_port_read.sv
// ---------------------------------------------------------------------------
// register_file_1w_multi_row_multi_port_read
//
// Latch-based memory of NUM_ROWS wide rows, one masked wide write port and
// N_READ independent narrow read ports. After reset a sequencer zero-fills
// every row (the latches themselves have no reset) and then raises InitDone.
//
// Ports:
//   clk          in  clock
//   rst          in  asynchronous active-high reset
//   ReadEnable   in  per-port read request, address captured on posedge
//   ReadAddr     in  per-port word address {row, word-in-row}
//   ReadData     out per-port word at the registered address
//   ReadValid    out per-port: previous cycle's request was accepted
//   WriteEnable  in  write request (honoured only once InitDone is high)
//   WriteAddr    in  row to write
//   WriteBE      in  per-word write mask
//   WriteData    in  row data
//   InitDone     out zero-fill finished, writes are accepted
// ---------------------------------------------------------------------------
module register_file_1w_multi_row_multi_port_read
    import scm_rf_pkg::*;
#(
    parameter  int WADDR_WIDTH = 2,
    parameter  int WDATA_WIDTH = 64,
    parameter  int RDATA_WIDTH = 32,
    parameter  int N_READ      = 4,
    localparam int RATIO       = WDATA_WIDTH / RDATA_WIDTH,
    localparam int RADDR_WIDTH = calc_raddr_width(WADDR_WIDTH, WDATA_WIDTH, RDATA_WIDTH)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_READ-1:0]                     ReadEnable,
    input  logic [N_READ-1:0][RADDR_WIDTH-1:0]    ReadAddr,
    output logic [N_READ-1:0][RDATA_WIDTH-1:0]    ReadData,
    output logic [N_READ-1:0]                     ReadValid,
    input  logic                                  WriteEnable,
    input  logic [WADDR_WIDTH-1:0]                WriteAddr,
    input  logic [RATIO-1:0]                      WriteBE,
    input  logic [WDATA_WIDTH-1:0]                WriteData,
    output logic                                  InitDone
);

    localparam int NUM_ROWS   = 2 ** WADDR_WIDTH;
    localparam int WSEL_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Geometry checks, evaluated once at elaboration.
    if ((WDATA_WIDTH % RDATA_WIDTH) != 0) begin : g_bad_width
        $error("WDATA_WIDTH must be an integer multiple of RDATA_WIDTH");
    end
    if (!is_pow2(RATIO)) begin : g_bad_ratio
        $error("WDATA_WIDTH/RDATA_WIDTH must be a power of 2");
    end

    init_state_e                        state;
    logic [WADDR_WIDTH-1:0]             init_row;
    logic                               init_done_q;

    logic [WDATA_WIDTH-1:0]             wdata_q;
    logic [NUM_ROWS-1:0]                wrow_q;
    logic [RATIO-1:0]                   wbe_q;
    logic [WDATA_WIDTH-1:0]             wdata_hold;

    logic [N_READ-1:0][RADDR_WIDTH-1:0] raddr_q;
    logic [RATIO-1:0][RDATA_WIDTH-1:0]  row_words [NUM_ROWS];

    // Zero-fill sequencer: one row per cycle, then READY until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            init_row    <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_row <= init_row + 1'b1;
                    if (init_row == WADDR_WIDTH'(NUM_ROWS - 1)) begin
                        state       <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign InitDone = init_done_q;

    // Write sample stage. During INIT the sequencer owns the port and external
    // writes are dropped; afterwards an accepted write is captured here. When
    // nothing is written the row select is cleared so no gate opens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdata_q <= '0;
            wrow_q  <= '0;
            wbe_q   <= '0;
        end else if (state == INIT) begin
            wdata_q <= '0;
            wrow_q  <= NUM_ROWS'(1) << init_row;
            wbe_q   <= '1;
        end else if (WriteEnable && init_done_q) begin
            wdata_q <= WriteData;
            wrow_q  <= NUM_ROWS'(1) << WriteAddr;
            wbe_q   <= WriteBE;
        end else begin
            wrow_q  <= '0;
        end
    end

    // The latches are open during the high phase after the next posedge, when
    // wdata_q may already hold the following write. A falling-edge copy keeps
    // the data stable across that whole high phase, so back-to-back writes
    // do not corrupt each other.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            wdata_hold <= '0;
        end else begin
            wdata_hold <= wdata_q;
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        scm_latch_row #(
            .RATIO       (RATIO),
            .RDATA_WIDTH (RDATA_WIDTH)
        ) u_row (
            .clk     (clk),
            .rst     (rst),
            .row_en  (wrow_q[r]),
            .word_en (wbe_q),
            .data    (wdata_hold),
            .words   (row_words[r])
        );
    end

    // Read address registers hold between requests, so ReadData keeps
    // following the same word (including later writes to it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q   <= '0;
            ReadValid <= '0;
        end else begin
            for (int z = 0; z < N_READ; z++) begin
                if (ReadEnable[z]) begin
                    raddr_q[z] <= ReadAddr[z];
                end
            end
            ReadValid <= ReadEnable & {N_READ{init_done_q}};
        end
    end

    for (genvar z = 0; z < N_READ; z++) begin : g_read
        logic [WADDR_WIDTH-1:0] row_sel;
        logic [WSEL_WIDTH-1:0]  word_sel;

        assign row_sel = raddr_q[z][RADDR_WIDTH-1 -: WADDR_WIDTH];

        // With one word per row there are no word-select address bits.
        if (RATIO > 1) begin : g_word_sel
            assign word_sel = raddr_q[z][WSEL_WIDTH-1:0];
        end else begin : g_single_word
            assign word_sel = '0;
        end

        assign ReadData[z] = row_words[row_sel][word_sel];
    end

endmodule

// File: tb/tb_register_file_1w_multi_row_multi_port_read.sv
// ---------------------------------------------------------------------------
// tb_register_file_1w_multi_row_multi_port_read
//
// Directed bench for the latch register file (default geometry: 4 rows of
// 2 x 32-bit words, 4 read ports). Expected read words are queued when a
// read is issued and compared once the data is due.
// ---------------------------------------------------------------------------
module tb_register_file_1w_multi_row_multi_port_read;

    localparam int WADDR_WIDTH = 2;
    localparam int WDATA_WIDTH = 64;
    localparam int RDATA_WIDTH = 32;
    localparam int N_READ      = 4;
    localparam int RATIO       = WDATA_WIDTH / RDATA_WIDTH;
    localparam int RADDR_WIDTH = 3;

    logic                                  clk = 1'b0;
    logic                                  rst;
    logic [N_READ-1:0]                     ReadEnable;
    logic [N_READ-1:0][RADDR_WIDTH-1:0]    ReadAddr;
    logic [N_READ-1:0][RDATA_WIDTH-1:0]    ReadData;
    logic [N_READ-1:0]                     ReadValid;
    logic                                  WriteEnable;
    logic [WADDR_WIDTH-1:0]                WriteAddr;
    logic [RATIO-1:0]                      WriteBE;
    logic [WDATA_WIDTH-1:0]                WriteData;
    logic                                  InitDone;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard of pending read expectations.
    int          exp_port [$];
    logic [31:0] exp_data [$];
    string       exp_tag  [$];

    always #5 clk = ~clk;

    register_file_1w_multi_row_multi_port_read #(
        .WADDR_WIDTH (WADDR_WIDTH),
        .WDATA_WIDTH (WDATA_WIDTH),
        .RDATA_WIDTH (RDATA_WIDTH),
        .N_READ      (N_READ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ReadEnable  (ReadEnable),
        .ReadAddr    (ReadAddr),
        .ReadData    (ReadData),
        .ReadValid   (ReadValid),
        .WriteEnable (WriteEnable),
        .WriteAddr   (WriteAddr),
        .WriteBE     (WriteBE),
        .WriteData   (WriteData),
        .InitDone    (InitDone)
    );

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic expectRead(input string tag, input int port, input logic [31:0] data);
        exp_tag.push_back(tag);
        exp_port.push_back(port);
        exp_data.push_back(data);
    endtask

    // Drain every queued expectation against the current read outputs.
    task automatic checkOutput();
        while (exp_port.size() > 0) begin
            string       tag;
            int          port;
            logic [31:0] data;
            tag  = exp_tag.pop_front();
            port = exp_port.pop_front();
            data = exp_data.pop_front();
            checkValue(tag, {32'h0, ReadData[port]}, {32'h0, data});
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] waddr,
                                 input logic [1:0] be, input logic [63:0] wdata,
                                 input logic [3:0] re,
                                 input logic [2:0] a0, input logic [2:0] a1,
                                 input logic [2:0] a2, input logic [2:0] a3);
        WriteEnable = we;
        WriteAddr   = waddr;
        WriteBE     = be;
        WriteData   = wdata;
        ReadEnable  = re;
        ReadAddr[0] = a0;
        ReadAddr[1] = a1;
        ReadAddr[2] = a2;
        ReadAddr[3] = a3;
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read all eight words on the four ports and expect zero everywhere.
    task automatic readAllZero(input string phase);
        for (int round = 0; round < 2; round++) begin
            applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'hF,
                          3'(4*round), 3'(4*round+1), 3'(4*round+2), 3'(4*round+3));
            for (int z = 0; z < N_READ; z++) begin
                expectRead($sformatf("%s_word%0d", phase, 4*round+z), z, 32'h0);
            end
            step();
            checkOutput();
            checkValue($sformatf("%s_valid%0d", phase, round), {60'h0, ReadValid}, 64'hF);
        end
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        step();
        checkValue("reset_initdone", {63'h0, InitDone}, 64'h0);
        checkValue("reset_valid", {60'h0, ReadValid}, 64'h0);

        // Release reset while hammering the write port with all-ones data;
        // those writes must be dropped during the zero-fill.
        rst = 1'b0;
        applyStimulus(1'b1, 2'd0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        for (int c = 1; c <= 4; c++) begin
            step();
            checkValue($sformatf("init_done_cycle%0d", c), {63'h0, InitDone},
                       (c == 4) ? 64'h1 : 64'h0);
        end
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        readAllZero("init");

        // Full-row write to row 2, then read both words.
        applyStimulus(1'b1, 2'd2, 2'b11, 64'hDEADBEEF_CAFEF00D, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'b0011, 3'd4, 3'd5, 3'd0, 3'd0);
        expectRead("basic_word4", 0, 32'hCAFEF00D);
        expectRead("basic_word5", 1, 32'hDEADBEEF);
        step();
        checkOutput();
        checkValue("basic_valid", {60'h0, ReadValid}, 64'h3);

        // Masked write: only the upper word of row 1 changes.
        applyStimulus(1'b1, 2'd1, 2'b11, 64'h11111111_22222222, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        applyStimulus(1'b1, 2'd1, 2'b10, 64'hAAAAAAAA_BBBBBBBB, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'b0011, 3'd3, 3'd2, 3'd0, 3'd0);
        expectRead("masked_word3", 0, 32'hAAAAAAAA);
        expectRead("masked_word2", 1, 32'h22222222);
        step();
        checkOutput();

        // Write with an empty mask leaves the row untouched.
        applyStimulus(1'b1, 2'd1, 2'b00, 64'h55555555_55555555, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'b0011, 3'd3, 3'd2, 3'd0, 3'd0);
        expectRead("nomask_word3", 0, 32'hAAAAAAAA);
        expectRead("nomask_word2", 1, 32'h22222222);
        step();
        checkOutput();

        // Same-edge hazard: all ports read word 0 as row 0 is written.
        applyStimulus(1'b1, 2'd0, 2'b11, 64'h00000001_00000002, 4'hF, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        checkValue("hazard_valid", {60'h0, ReadValid}, 64'hF);
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        for (int z = 0; z < N_READ; z++) begin
            expectRead($sformatf("hazard_port%0d", z), z, 32'h2);
        end
        step();
        checkOutput();
        checkValue("hazard_valid_after", {60'h0, ReadValid}, 64'h0);

        // Held address: port 3 keeps watching word 5 while it is rewritten.
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'b1000, 3'd0, 3'd0, 3'd0, 3'd5);
        expectRead("held_before", 3, 32'hDEADBEEF);
        step();
        checkOutput();
        checkValue("held_valid_issue", {63'h0, ReadValid[3]}, 64'h1);
        applyStimulus(1'b1, 2'd2, 2'b10, 64'h00000055_00000066, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        expectRead("held_after", 3, 32'h55);
        expectRead("held_port0_word0", 0, 32'h2);
        step();
        checkOutput();
        checkValue("held_valid", {63'h0, ReadValid[3]}, 64'h0);

        // Reset lands right after a write to row 0 is sampled: the old word
        // must survive until the zero-fill rewrites the array.
        applyStimulus(1'b1, 2'd0, 2'b11, 64'h00000099_00000088, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        step();
        rst = 1'b1;
        applyStimulus(1'b0, 2'd0, 2'b00, 64'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0);
        expectRead("midreset_no_commit", 0, 32'h2);
        step();
        checkOutput();
        checkValue("midreset_initdone", {63'h0, InitDone}, 64'h0);
        checkValue("midreset_valid", {60'h0, ReadValid}, 64'h0);
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            checkValue($sformatf("reinit_done_cycle%0d", c), {63'h0, InitDone},
                       (c == 4) ? 64'h1 : 64'h0);
        end
        readAllZero("reinit");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
